knn_vote: RTL

Majority-vote classifier stage that sits directly downstream of the k-nearest-neighbour list in the KNN accelerator. Once the list has settled for a test point, it streams its NBR_KNN surviving entries here (class label plus distance), nearest first. This block builds a per-class histogram, selects the winning class and presents one classification result per test point over a valid/ready handshake. Ties are broken in favour of the class whose nearest member ranks closest.

---
 rtl/knn_pkg.sv | 18 +
 rtl/knn_class_hist.sv | 43 ++++
 rtl/knn_vote.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/knn_pkg.sv
// Shared KNN accelerator definitions: FSM encoding, default label width and
// the vote-count width derivation used by the list and the vote stage.
package knn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } knn_state_t;

    localparam int unsigned DEF_CLASS_W = 2;

    function automatic int unsigned knn_cnt_w(input int unsigned nbr_knn);
        return $clog2(nbr_knn + 1);
    endfunction

endpackage

// File: rtl/knn_class_hist.sv
// Per-class vote counters and first-rank registers, indexed by class label.
module knn_class_hist #(
    parameter int unsigned NBR_CLASSES = 4,
    parameter int unsigned CLASS_W     = 2,
    parameter int unsigned CNT_W       = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    input  logic [CLASS_W-1:0] inc_label,
    input  logic [CNT_W-1:0]   inc_rank,
    input  logic [CLASS_W-1:0] rd_class,
    output logic [CNT_W-1:0]   rd_cnt,
    output logic [CNT_W-1:0]   rd_rank
);

    logic [CNT_W-1:0] cnt        [NBR_CLASSES];
    logic [CNT_W-1:0] first_rank [NBR_CLASSES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NBR_CLASSES; i++) begin
                cnt[i]        <= '0;
                first_rank[i] <= '0;
            end
        end else if (clr) begin
            for (int unsigned i = 0; i < NBR_CLASSES; i++) begin
                cnt[i]        <= '0;
                first_rank[i] <= '0;
            end
        end else if (inc) begin
            cnt[inc_label] <= cnt[inc_label] + 1'b1;
            // Only the nearest member of a class defines its tie-break rank.
            if (cnt[inc_label] == '0)
                first_rank[inc_label] <= inc_rank;
        end
    end

    assign rd_cnt  = cnt[rd_class];
    assign rd_rank = first_rank[rd_class];

endmodule

// File: rtl/knn_vote.sv
// Majority-vote stage: histograms NBR_KNN labelled neighbours, picks the winner
// (ties to the class with the nearest member) and emits it over valid/ready.
module knn_vote
    import knn_pkg::*;
#(
    parameter  int unsigned DATA_W  = 32,
    parameter  int unsigned NBR_KNN = 4,
    parameter  int unsigned CLASS_W = DEF_CLASS_W,
    localparam int unsigned CNT_W   = knn_cnt_w(NBR_KNN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CLASS_W-1:0] in_label,
    input  logic [DATA_W-1:0]  in_dist,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLASS_W-1:0] out_label,
    output logic [CNT_W-1:0]   out_count,
    output logic               busy,
    output logic               order_err
);

    localparam int unsigned NBR_CLASSES = 2 ** CLASS_W;

    knn_state_t         state;
    logic [CNT_W-1:0]   beat;
    logic [DATA_W-1:0]  prev_dist;
    logic [CLASS_W-1:0] scan_idx;
    logic [CLASS_W-1:0] best_label;
    logic [CNT_W-1:0]   best_cnt;
    logic [CNT_W-1:0]   best_rank;

    logic               hist_clr;
    logic               hist_inc;
    logic [CNT_W-1:0]   rd_cnt;
    logic [CNT_W-1:0]   rd_rank;

    logic               take;
    logic [CLASS_W-1:0] nxt_label;
    logic [CNT_W-1:0]   nxt_cnt;
    logic [CNT_W-1:0]   nxt_rank;

    assign hist_clr = (state == IDLE) && start;
    assign hist_inc = (state == LOAD) && in_valid;

    knn_class_hist #(
        .NBR_CLASSES (NBR_CLASSES),
        .CLASS_W     (CLASS_W),
        .CNT_W       (CNT_W)
    ) u_hist (
        .clk       (clk),
        .rst       (rst),
        .clr       (hist_clr),
        .inc       (hist_inc),
        .inc_label (in_label),
        .inc_rank  (beat),
        .rd_class  (scan_idx),
        .rd_cnt    (rd_cnt),
        .rd_rank   (rd_rank)
    );

    always_comb begin
        take = (rd_cnt > best_cnt) ||
               ((rd_cnt == best_cnt) && (rd_cnt != '0) && (rd_rank < best_rank));
        nxt_label = take ? scan_idx : best_label;
        nxt_cnt   = take ? rd_cnt   : best_cnt;
        nxt_rank  = take ? rd_rank  : best_rank;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            beat       <= '0;
            prev_dist  <= '0;
            scan_idx   <= '0;
            best_label <= '0;
            best_cnt   <= '0;
            best_rank  <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_label  <= '0;
            out_count  <= '0;
            busy       <= 1'b0;
            order_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LOAD;
                        beat       <= '0;
                        best_label <= '0;
                        best_cnt   <= '0;
                        best_rank  <= '0;
                        order_err  <= 1'b0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        beat      <= beat + 1'b1;
                        prev_dist <= in_dist;
                        if ((beat != '0) && (in_dist < prev_dist))
                            order_err <= 1'b1;
                        if (beat == CNT_W'(NBR_KNN - 1)) begin
                            state      <= SCAN;
                            in_ready   <= 1'b0;
                            scan_idx   <= '0;
                            best_label <= '0;
                            best_cnt   <= '0;
                            best_rank  <= CNT_W'(NBR_KNN);
                        end
                    end
                end
                SCAN: begin
                    best_label <= nxt_label;
                    best_cnt   <= nxt_cnt;
                    best_rank  <= nxt_rank;
                    scan_idx   <= scan_idx + 1'b1;
                    // The last class's decision is folded straight into the result.
                    if (scan_idx == CLASS_W'(NBR_CLASSES - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_label <= nxt_label;
                        out_count <= nxt_cnt;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
